// File: rtl/stage3_types_pkg.sv
// Shared types and helpers for the stage-3 hart PC scheduler.
package stage3_types_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    SLEEP    = 2'd2
  } hart_state_t;

  // Upper bound on hart count supported by the shared arbiter helper.
  localparam int MAX_HARTS     = 32;
  localparam int HART_ID_MAX_W = 5;

  typedef logic [HART_ID_MAX_W-1:0] hart_id_t;

  localparam logic [31:0] PC_INCR = 32'd4;

  // First set bit of req at or after ptr, wrapping at n. Pass ptr=0 for
  // lowest-index-wins priority. Returns 0 when req is empty.
  function automatic hart_id_t rr_pick(input logic [MAX_HARTS-1:0] req,
                                       input logic [31:0]          ptr,
                                       input logic [31:0]          n);
    hart_id_t    pick;
    logic        found;
    logic [31:0] base;
    logic [31:0] idx;
    pick  = '0;
    found = 1'b0;
    base  = (ptr < n) ? ptr : 32'd0;
    for (int off = 0; off < MAX_HARTS; off++) begin
      idx = base + 32'(off);
      if (idx >= n) idx = idx - n;
      if (!found && (32'(off) < n) && req[idx[HART_ID_MAX_W-1:0]]) begin
        pick  = idx[HART_ID_MAX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stage3_rr_arbiter.sv
// Combinational round-robin / fixed-priority arbiter over a request vector.
module stage3_rr_arbiter
  import stage3_types_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MODE    = 0,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_grant
);

  logic [MAX_HARTS-1:0] req_ext;
  hart_id_t             pick;

  // Widen the request vector and pick the winner; MODE 1 ignores the pointer.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick      = rr_pick(req_ext, (MODE == 1) ? 32'd0 : 32'(ptr), 32'(NUM_REQ));
    grant     = ID_W'(pick);
    any_grant = |req;
  end

endmodule

// File: rtl/stage3_hart_pc_scheduler.sv
// Per-hart PC registers and run-state FSMs, with a valid/ready fetch offer.
module stage3_hart_pc_scheduler
  import stage3_types_pkg::*;
#(
  parameter int          NUM_HARTS      = 4,
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter logic [31:0] HART_PC_STRIDE = 32'h0,
  parameter int          SCHED_MODE     = 0,
  parameter int          HART_ID_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_HARTS-1:0]    hart_en,
  output logic                    fetch_valid,
  input  logic                    fetch_ready,
  output logic [31:0]             fetch_pc,
  output logic [HART_ID_W-1:0]    fetch_hart_id,
  input  logic                    redirect_valid,
  input  logic [HART_ID_W-1:0]    redirect_hart,
  input  logic [31:0]             redirect_pc,
  input  logic [NUM_HARTS-1:0]    halt_req,
  input  logic [NUM_HARTS-1:0]    wake,
  output logic [NUM_HARTS*32-1:0] hart_pc,
  output logic [NUM_HARTS-1:0]    hart_running
);

  logic [31:0]          pc_vec [NUM_HARTS];
  logic [NUM_HARTS-1:0] eligible;
  logic [HART_ID_W-1:0] rr_ptr_reg;
  logic                 lock_reg;
  logic [HART_ID_W-1:0] lock_hart_reg;
  logic [HART_ID_W-1:0] arb_grant;
  logic                 arb_any;
  logic [HART_ID_W-1:0] sel;
  logic [HART_ID_W-1:0] rr_ptr_next;
  logic                 accept;
  logic                 redirect_hit;
  logic                 unused_pc_lsbs;

  // The low two redirect bits are discarded; PCs are always word aligned.
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign redirect_hit   = redirect_valid && (32'(redirect_hart) < 32'(NUM_HARTS));

  stage3_rr_arbiter #(
    .NUM_REQ (NUM_HARTS),
    .MODE    (SCHED_MODE),
    .ID_W    (HART_ID_W)
  ) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_reg),
    .grant     (arb_grant),
    .any_grant (arb_any)
  );

  // A locked offer overrides arbitration; nothing is offered during reset.
  always_comb begin
    sel           = lock_reg ? lock_hart_reg : arb_grant;
    fetch_valid   = !RST && (lock_reg || arb_any);
    fetch_pc      = fetch_valid ? pc_vec[sel] : 32'd0;
    fetch_hart_id = fetch_valid ? sel : '0;
    accept        = fetch_valid && fetch_ready;
    rr_ptr_next   = (sel == HART_ID_W'(NUM_HARTS - 1)) ? '0 : sel + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
    hart_state_t state_reg;
    logic [31:0] pc_reg;
    logic        redir_here;
    logic        accept_here;

    assign redir_here  = redirect_hit && (redirect_hart == HART_ID_W'(gi));
    assign accept_here = accept && (sel == HART_ID_W'(gi));

    // Run-state FSM: enable dominates, wake beats a simultaneous halt.
    always_ff @(posedge CLK) begin
      if (RST) begin
        state_reg <= hart_en[gi] ? RUN : DISABLED;
      end else if (!hart_en[gi]) begin
        state_reg <= DISABLED;
      end else begin
        case (state_reg)
          DISABLED: state_reg <= RUN;
          RUN:      if (halt_req[gi] && !wake[gi]) state_reg <= SLEEP;
          SLEEP:    if (wake[gi] || redir_here) state_reg <= RUN;
          default:  state_reg <= DISABLED;
        endcase
      end
    end

    // PC update: a redirect beats the post-accept increment.
    always_ff @(posedge CLK) begin
      if (RST) begin
        pc_reg <= RESET_PC + 32'(gi) * HART_PC_STRIDE;
      end else if (redir_here) begin
        pc_reg <= {redirect_pc[31:2], 2'b00};
      end else if (accept_here) begin
        pc_reg <= pc_reg + PC_INCR;
      end
    end

    assign pc_vec[gi]            = pc_reg;
    assign eligible[gi]          = (state_reg == RUN);
    assign hart_running[gi]      = (state_reg == RUN);
    assign hart_pc[gi*32 +: 32]  = pc_reg;
  end

  // Hold the offered hart until fetch takes it; advance the pointer on accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_reg      <= 1'b0;
      lock_hart_reg <= '0;
      rr_ptr_reg    <= '0;
    end else if (accept) begin
      lock_reg      <= 1'b0;
      rr_ptr_reg    <= rr_ptr_next;
    end else if (fetch_valid) begin
      lock_reg      <= 1'b1;
      lock_hart_reg <= sel;
    end
  end

endmodule
